data_memory: RTL and testbench

- 256 x 8-bit data memory for the microprocessor datapath.
- Sits between the ALU result (address) and the register-file write-back mux (ReadD).
- Writes are synchronous. Reads are combinational and gated by MemRead.
- Synchronous reset loads a defined initial image so the program can read known data before any write.

---
 rtl/data_memory.sv | 38 +++
 tb/tb_data_memory.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// 256 x 8 data memory: synchronous write, combinational read gated by MemRead.
// A reset edge loads the identity image mem[a] = a so programs can read known data.
module data_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] WriteD,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadD
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset has priority: the full image is restored and any write on that edge is dropped.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= DATA_W'(i);
      end
    end else if (MemWrite) begin
      mem[address] <= WriteD;
    end
  end

  always_comb begin
    ReadD = '0;
    if (MemRead && !Reset) begin
      ReadD = mem[address];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases followed by random traffic
// compared against an array-based reference model.
module tb_data_memory;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] address;
  logic [7:0] WriteD;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] ReadD;

  int checks = 0;
  int errors = 0;

  logic [7:0] refMem [256];

  data_memory #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .address (address),
    .WriteD  (WriteD),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .ReadD   (ReadD)
  );

  always #10 clk = ~clk;

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expRead();
    return (MemRead && !Reset) ? refMem[address] : 8'h00;
  endfunction

  // One rising edge; the model applies what the memory should do on that edge.
  task automatic tick();
    @(posedge clk);
    if (Reset) begin
      for (int i = 0; i < 256; i++) refMem[i] = 8'(i);
    end else if (MemWrite) begin
      refMem[address] = WriteD;
    end
    #1;
  endtask

  initial begin
    Reset    = 1'b1;
    address  = 8'h00;
    WriteD   = 8'h00;
    MemRead  = 1'b1;
    MemWrite = 1'b0;

    // Reset held for 5 clocks; ReadD must stay 0 even with MemRead high.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("rst_hold", ReadD, 8'h00);
    end
    Reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 8'(a);
      #1;
      checkEq("rst_image", ReadD, 8'(a));
    end

    // Write 0x55 to 0..3 with MemRead low.
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    WriteD   = 8'h55;
    for (int a = 0; a < 4; a++) begin
      address = 8'(a);
      tick();
      checkEq("wr_noread", ReadD, 8'h00);
    end
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 8'(a);
      #1;
      checkEq("wr_readback", ReadD, 8'h55);
    end
    address = 8'h04;
    #1;
    checkEq("neighbour", ReadD, 8'h04);

    // Read gating at the top address.
    MemRead = 1'b0;
    address = 8'hFF;
    #1;
    checkEq("gate_low", ReadD, 8'h00);
    MemRead = 1'b1;
    #1;
    checkEq("gate_high", ReadD, 8'hFF);

    // Simultaneous read and write: old data before the edge, new data after.
    address  = 8'h10;
    WriteD   = 8'hA5;
    MemWrite = 1'b1;
    #1;
    checkEq("rw_before", ReadD, 8'h10);
    tick();
    checkEq("rw_after", ReadD, 8'hA5);
    MemWrite = 1'b0;

    // Reset beats a concurrent write and restores the image.
    address  = 8'h00;
    #1;
    checkEq("pre_rst_addr0", ReadD, 8'h55);
    Reset    = 1'b1;
    MemWrite = 1'b1;
    WriteD   = 8'hFF;
    #1;
    checkEq("rst_comb_zero", ReadD, 8'h00);
    tick();
    Reset    = 1'b0;
    MemWrite = 1'b0;
    #1;
    checkEq("rst_beats_wr", ReadD, 8'h00);
    address = 8'h10;
    #1;
    checkEq("rst_restore", ReadD, 8'h10);

    // No write without an enabled edge.
    address  = 8'h80;
    WriteD   = 8'h3C;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    address  = 8'h81;
    WriteD   = 8'h11;
    #3;
    address  = 8'h82;
    WriteD   = 8'h22;
    tick();
    tick();
    address = 8'h80;
    #1;
    checkEq("hold_80", ReadD, 8'h3C);
    address = 8'h81;
    #1;
    checkEq("hold_81", ReadD, 8'h81);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      Reset    = ($urandom_range(0, 31) == 0);
      MemWrite = $urandom_range(0, 1) == 1;
      MemRead  = $urandom_range(0, 3) != 0;
      address  = 8'($urandom);
      WriteD   = 8'($urandom);
      #1;
      checkEq("rnd_pre", ReadD, expRead());
      tick();
      checkEq("rnd_post", ReadD, expRead());
    end

    // Final sweep of the whole array.
    Reset    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    for (int a = 0; a < 256; a++) begin
      address = 8'(a);
      #1;
      checkEq("sweep", ReadD, refMem[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
